// File: rtl/sum4_arbiter.sv
// Round-robin arbiter sharing one registered four-operand adder among NREQ requesters.
// Each accepted request takes three cycles: grant, sum, done.
module sum4_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int IDW   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*4*WIDTH-1:0] opnd,
  output logic [NREQ-1:0]         gnt,
  output logic [IDW-1:0]          gnt_id,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH+1:0]        res,
  output logic [IDW-1:0]          res_id
);

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH+1:0] res_q, res_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             op_ld;
  logic [WIDTH-1:0] op_a_q, op_b_q, op_c_q, op_d_q;

  logic             win_any;
  logic             hi_found;
  logic [IDW-1:0]   hi_idx, lo_idx, win_id, rr_next;
  logic [NREQ-1:0]  win_oh;
  logic [4*WIDTH-1:0] win_ops;

  function automatic logic [WIDTH+1:0] sum4(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c,
                                            input logic [WIDTH-1:0] d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    win_any  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_any = 1'b1;
        lo_idx  = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    win_id  = hi_found ? hi_idx : lo_idx;
    rr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
  end

  always_comb begin
    win_oh  = '0;
    win_ops = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win_id) begin
        win_oh[i] = 1'b1;
        win_ops   = opnd[i*4*WIDTH +: 4*WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  // Operand holding registers carry data only, so they need no reset.
  always_ff @(posedge clk) begin
    if (op_ld) begin
      op_a_q <= win_ops[4*WIDTH-1 -: WIDTH];
      op_b_q <= win_ops[3*WIDTH-1 -: WIDTH];
      op_c_q <= win_ops[2*WIDTH-1 -: WIDTH];
      op_d_q <= win_ops[WIDTH-1   -: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = win_any ? S_SUM : S_IDLE;
      S_SUM:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_id_d = res_id_q;
    rr_ptr_d = rr_ptr_q;
    op_ld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = win_any;
        if (win_any) begin
          gnt_d    = win_oh;
          gnt_id_d = win_id;
          rr_ptr_d = rr_next;
          op_ld    = 1'b1;
        end
      end
      S_SUM: begin
        busy_d   = 1'b1;
        done_d   = 1'b1;
        res_d    = sum4(op_a_q, op_b_q, op_c_q, op_d_q);
        res_id_d = gnt_id_q;
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign res    = res_q;
  assign res_id = res_id_q;

endmodule

// File: tb/tb_sum4_arbiter.sv
// Bench for sum4_arbiter (NREQ=2, WIDTH=4): vector table plus hand-written
// sequences for reset-abort and late-request timing; results checked through a queue.
module tb_sum4_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] opnd;
  logic [1:0]  gnt;
  logic [2:0]  gnt_id;
  logic        busy;
  logic        done;
  logic [5:0]  res;
  logic [2:0]  res_id;

  sum4_arbiter #(.NREQ(2), .WIDTH(4), .IDW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .opnd(opnd),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .done(done),
    .res(res), .res_id(res_id)
  );

  typedef struct {
    logic [1:0]  req;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [1:0]  exp_gnt;
    logic [2:0]  exp_id;
    logic [5:0]  exp_res;
    bit          hold;
  } vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_gnt_cyc = 0;
  logic [8:0] exp_q[$];
  vec_t       vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pops one expected {res, res_id}.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got res=%0d id=%0d expected no done", res, res_id);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("res", 32'(res), 32'(e[8:3]));
        chk("res_id", 32'(res_id), 32'(e[2:0]));
        chk("gnt_with_done", 32'(gnt), 0);
      end
    end
  end

  task automatic wait_gnt(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: got gnt=0 expected a grant within 6 cycles");
    end
  endtask

  task automatic run_vec(input vec_t v, input bit chk_gap);
    bit seen;
    req  = v.req;
    opnd = {v.op1, v.op0};
    exp_q.push_back({v.exp_res, v.exp_id});
    wait_gnt(seen);
    if (!seen) begin
      req = 2'b00;
      return;
    end
    chk("gnt", 32'(gnt), 32'(v.exp_gnt));
    chk("gnt_id", 32'(gnt_id), 32'(v.exp_id));
    chk("busy_sum", 32'(busy), 1);
    chk("done_in_gnt", 32'(done), 0);
    if (chk_gap) chk("gnt_gap", 32'(cyc - last_gnt_cyc), 3);
    last_gnt_cyc = cyc;
    // Granted operands may change from the grant cycle on.
    if (gnt[0]) opnd[15:0] = 16'($urandom);
    else        opnd[31:16] = 16'($urandom);
    if (!v.hold) req = 2'b00;
    @(negedge clk);
    chk("done_latency", 32'(done), 1);
    chk("busy_done", 32'(busy), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit prev_hold;

    vecs[0] = '{2'b01, {4'd7, 4'd8, 4'd5, 4'd3},    16'h0, 2'b01, 3'd0, 6'd23, 1'b0};
    vecs[1] = '{2'b01, {4'd13, 4'd1, 4'd7, 4'd12},  16'h0, 2'b01, 3'd0, 6'd33, 1'b0};
    vecs[2] = '{2'b10, 16'h0, {4'd1, 4'd2, 4'd3, 4'd4}, 2'b10, 3'd1, 6'd10, 1'b0};
    vecs[3] = '{2'b11, {4'd3, 4'd9, 4'd1, 4'd10}, {4'd9, 4'd10, 4'd11, 4'd5}, 2'b01, 3'd0, 6'd23, 1'b1};
    vecs[4] = '{2'b11, {4'd3, 4'd9, 4'd1, 4'd10}, {4'd9, 4'd10, 4'd11, 4'd5}, 2'b10, 3'd1, 6'd35, 1'b1};
    vecs[5] = '{2'b11, {4'd3, 4'd9, 4'd1, 4'd10}, {4'd9, 4'd10, 4'd11, 4'd5}, 2'b01, 3'd0, 6'd23, 1'b1};
    vecs[6] = '{2'b11, {4'd3, 4'd9, 4'd1, 4'd10}, {4'd9, 4'd10, 4'd11, 4'd5}, 2'b10, 3'd1, 6'd35, 1'b1};
    vecs[7] = '{2'b01, {4'd15, 4'd15, 4'd15, 4'd15}, 16'h0, 2'b01, 3'd0, 6'd60, 1'b0};
    vecs[8] = '{2'b10, 16'hFFFF, 16'h0, 2'b10, 3'd1, 6'd0, 1'b0};

    rst  = 1'b1;
    req  = 2'b00;
    opnd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_res_id", 32'(res_id), 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ctrl", {29'd0, gnt, busy | done}, 0);
      chk("idle_res", 32'(res), 0);
    end

    prev_hold = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], vecs[i].hold && prev_hold);
      prev_hold = vecs[i].hold;
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // Reset during SUM aborts the op and returns the pointer to requester 0.
    req  = 2'b01;
    opnd = {16'h0, 4'd1, 4'd2, 4'd3, 4'd4};
    wait_gnt(seen);
    chk("abort_gnt", 32'(gnt), 1);
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_res", 32'(res), 0);
    chk("abort_res_id", 32'(res_id), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done2", 32'(done), 0);
    run_vec('{2'b11, {4'd2, 4'd2, 4'd2, 4'd2}, {4'd9, 4'd9, 4'd9, 4'd9}, 2'b01, 3'd0, 6'd8, 1'b0}, 1'b0);
    @(negedge clk);

    // Request raised during SUM waits for the next IDLE evaluation.
    req  = 2'b01;
    opnd = {16'h0, 4'd5, 4'd6, 4'd7, 4'd8};
    exp_q.push_back({6'd26, 3'd0});
    wait_gnt(seen);
    chk("late_gnt0", 32'(gnt), 1);
    req  = 2'b10;
    opnd = {4'd15, 4'd14, 4'd1, 4'd0, 16'($urandom)};
    exp_q.push_back({6'd30, 3'd1});
    @(negedge clk);
    chk("late_done0", 32'(done), 1);
    chk("late_no_gnt_done", 32'(gnt), 0);
    @(negedge clk);
    chk("late_no_gnt_idle", 32'(gnt), 0);
    @(negedge clk);
    chk("late_gnt1", 32'(gnt), 2);
    chk("late_gnt1_id", 32'(gnt_id), 1);
    req = 2'b00;
    @(negedge clk);
    chk("late_done1", 32'(done), 1);

    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
